// File: rtl/icache_axi_refill_if.sv
// rtl/icache_axi_refill_if.sv - AXI4 read-address and read-data channel bundle for the icache refill master
interface icache_axi_refill_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/icache_axi_refill.sv
// rtl/icache_axi_refill.sv - single-outstanding icache line refill over one AXI4 INCR read burst
module icache_axi_refill #(
    parameter int          LINE_WORDS = 4,
    parameter logic [3:0]  AXI_ID     = 4'd0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     icache_rd_req,
    input  logic [31:0]              icache_rd_addr,
    output logic                     icache_rd_rdy,
    output logic                     icache_ret_valid,
    output logic [32*LINE_WORDS-1:0] icache_ret_data,
    icache_axi_refill_if.master      axi
);

    localparam int CW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        AR    = 2'd1,
        RDATA = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                         state_q, state_d;
    logic [31:0]                    araddr_q;
    logic [LINE_WORDS-1:0][31:0]    line_q;
    logic [CW-1:0]                  cnt_q;
    logic                           accept;
    logic                           beat_ok;

    // Response code is deliberately ignored; beats are stored whatever the response.
    logic [1:0] unused_rresp;
    assign unused_rresp = axi.rresp;

    assign axi.arid    = AXI_ID;
    assign axi.arlen   = 8'(LINE_WORDS - 1);
    assign axi.arsize  = 3'b010;
    assign axi.arburst = 2'b01;
    assign axi.araddr  = araddr_q;

    // Word k of the line sits at bits [32k+31:32k].
    assign icache_ret_data = line_q;

    // State register; reset abandons any burst in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs, all decoded from the current state.
    always_comb begin
        state_d          = state_q;
        icache_rd_rdy    = 1'b0;
        icache_ret_valid = 1'b0;
        axi.arvalid      = 1'b0;
        axi.rready       = 1'b0;
        accept           = 1'b0;
        beat_ok          = 1'b0;
        case (state_q)
            IDLE: begin
                icache_rd_rdy = !reset;
                if (icache_rd_req && !reset) begin
                    accept  = 1'b1;
                    state_d = AR;
                end
            end
            AR: begin
                axi.arvalid = 1'b1;
                if (axi.arready) begin
                    state_d = RDATA;
                end
            end
            RDATA: begin
                // Foreign-ID beats are still acknowledged so the bus keeps moving.
                axi.rready = 1'b1;
                if (axi.rvalid && (axi.rid == AXI_ID)) begin
                    beat_ok = 1'b1;
                    if (axi.rlast) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                icache_ret_valid = 1'b1;
                state_d          = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Address latch, line buffer and beat counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            araddr_q <= 32'h0;
            line_q   <= '0;
            cnt_q    <= '0;
        end else if (accept) begin
            araddr_q <= {icache_rd_addr[31:4], 4'b0000};
            line_q   <= '0;
            cnt_q    <= '0;
        end else if (beat_ok) begin
            // Overlong bursts keep overwriting the last word until rlast arrives.
            line_q[cnt_q] <= axi.rdata;
            if (cnt_q != LAST_IDX) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_icache_axi_refill.sv
// tb/tb_icache_axi_refill.sv - directed self-checking bench for icache_axi_refill
module tb_icache_axi_refill;

    logic         clk = 1'b0;
    logic         reset;
    logic         req;
    logic [31:0]  addr;
    logic         rdy;
    logic         ret_valid;
    logic [127:0] ret_data;
    int           total = 0;
    int           bad = 0;
    int           pulses = 0;
    int           p0;

    always #5 clk = ~clk;

    icache_axi_refill_if axi ();

    icache_axi_refill #(.LINE_WORDS(4), .AXI_ID(4'd0)) dut (
        .clk              (clk),
        .reset            (reset),
        .icache_rd_req    (req),
        .icache_rd_addr   (addr),
        .icache_rd_rdy    (rdy),
        .icache_ret_valid (ret_valid),
        .icache_ret_data  (ret_data),
        .axi              (axi)
    );

    always @(posedge clk) begin
        if (ret_valid === 1'b1) pulses <= pulses + 1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [31:0] a, input logic [31:0] exp_addr);
        req = 1'b1;
        addr = a;
        #1;
        chk("rdy_in_idle", 128'(rdy), 128'(1'b1));
        step();
        req = 1'b0;
        chk("arvalid", 128'(axi.arvalid), 128'(1'b1));
        chk("araddr", 128'(axi.araddr), 128'(exp_addr));
        chk("rdy_busy", 128'(rdy), 128'(1'b0));
    endtask

    task automatic ar_hs(input int stall, input logic [31:0] exp_addr);
        axi.arready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            step();
            chk("stall_arvalid", 128'(axi.arvalid), 128'(1'b1));
            chk("stall_araddr", 128'(axi.araddr), 128'(exp_addr));
            chk("stall_rdy", 128'(rdy), 128'(1'b0));
        end
        axi.arready = 1'b1;
        step();
        axi.arready = 1'b0;
        chk("rready_on", 128'(axi.rready), 128'(1'b1));
        chk("arvalid_off", 128'(axi.arvalid), 128'(1'b0));
    endtask

    task automatic beat(input logic [3:0] id, input logic [31:0] d, input logic last, input int gap);
        for (int i = 0; i < gap; i++) begin
            axi.rvalid = 1'b0;
            step();
            chk("gap_rready", 128'(axi.rready), 128'(1'b1));
            chk("gap_no_ret", 128'(ret_valid), 128'(1'b0));
        end
        axi.rvalid = 1'b1;
        axi.rid = id;
        axi.rdata = d;
        axi.rlast = last;
        step();
        axi.rvalid = 1'b0;
        axi.rlast = 1'b0;
        axi.rid = 4'd0;
    endtask

    task automatic four_beats(input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3);
        beat(4'd0, w0, 1'b0, 0);
        beat(4'd0, w1, 1'b0, 0);
        beat(4'd0, w2, 1'b0, 0);
        beat(4'd0, w3, 1'b1, 0);
    endtask

    task automatic done_chk(input string tag, input logic [127:0] exp_line);
        chk({tag, "_ret_valid"}, 128'(ret_valid), 128'(1'b1));
        chk({tag, "_ret_data"}, ret_data, exp_line);
        p0 = pulses;
        step();
        chk({tag, "_one_pulse"}, 128'(pulses - p0), 128'(1));
        chk({tag, "_ret_low"}, 128'(ret_valid), 128'(1'b0));
        chk({tag, "_data_held"}, ret_data, exp_line);
        chk({tag, "_back_idle"}, 128'(rdy), 128'(1'b1));
    endtask

    initial begin
        reset = 1'b1;
        req = 1'b0;
        addr = 32'h0;
        axi.arready = 1'b1;
        axi.rvalid = 1'b0;
        axi.rid = 4'd0;
        axi.rdata = 32'h0;
        axi.rresp = 2'b00;
        axi.rlast = 1'b0;
        step();
        step();
        chk("rst_rdy_low", 128'(rdy), 128'(1'b0));
        chk("rst_arvalid", 128'(axi.arvalid), 128'(1'b0));
        chk("rst_rready", 128'(axi.rready), 128'(1'b0));
        chk("rst_ret_valid", 128'(ret_valid), 128'(1'b0));
        chk("rst_ret_data", ret_data, 128'h0);
        chk("rst_araddr", 128'(axi.araddr), 128'h0);
        chk("arid", 128'(axi.arid), 128'(4'd0));
        chk("arlen", 128'(axi.arlen), 128'(8'd3));
        chk("arsize", 128'(axi.arsize), 128'(3'b010));
        chk("arburst", 128'(axi.arburst), 128'(2'b01));
        reset = 1'b0;
        #1;
        chk("idle_rdy", 128'(rdy), 128'(1'b1));

        // 1: basic refill, minimum latency
        accept(32'h1FC0_0024, 32'h1FC0_0020);
        axi.arready = 1'b1;
        step();
        chk("t1_rready", 128'(axi.rready), 128'(1'b1));
        four_beats(32'h11, 32'h22, 32'h33, 32'h44);
        done_chk("t1", 128'h00000044_00000033_00000022_00000011);

        // 2: arready stalled for five cycles
        accept(32'h1FC0_0024, 32'h1FC0_0020);
        ar_hs(5, 32'h1FC0_0020);
        four_beats(32'h11, 32'h22, 32'h33, 32'h44);
        done_chk("t2", 128'h00000044_00000033_00000022_00000011);

        // 3: rvalid gaps
        accept(32'h1FC0_0024, 32'h1FC0_0020);
        ar_hs(0, 32'h1FC0_0020);
        beat(4'd0, 32'h11, 1'b0, 0);
        beat(4'd0, 32'h22, 1'b0, 2);
        beat(4'd0, 32'h33, 1'b0, 1);
        beat(4'd0, 32'h44, 1'b1, 0);
        done_chk("t3", 128'h00000044_00000033_00000022_00000011);

        // 4: foreign-ID beat (with rlast) interleaved and dropped
        accept(32'h1FC0_0024, 32'h1FC0_0020);
        ar_hs(0, 32'h1FC0_0020);
        beat(4'd0, 32'h11, 1'b0, 0);
        beat(4'd5, 32'hDEAD_BEEF, 1'b1, 0);
        chk("t4_ignored_rlast", 128'(ret_valid), 128'(1'b0));
        chk("t4_still_rready", 128'(axi.rready), 128'(1'b1));
        beat(4'd0, 32'h22, 1'b0, 0);
        beat(4'd0, 32'h33, 1'b0, 0);
        beat(4'd0, 32'h44, 1'b1, 0);
        done_chk("t4", 128'h00000044_00000033_00000022_00000011);

        // 5: early rlast, then back-to-back request with an overlong burst
        accept(32'h1FC0_0024, 32'h1FC0_0020);
        ar_hs(0, 32'h1FC0_0020);
        beat(4'd0, 32'h11, 1'b0, 0);
        beat(4'd0, 32'h22, 1'b1, 0);
        chk("t5_ret_valid", 128'(ret_valid), 128'(1'b1));
        chk("t5_short_line", ret_data, 128'h00000000_00000000_00000022_00000011);
        req = 1'b1;
        addr = 32'h0000_100C;
        step();
        chk("t5b_rdy_after_done", 128'(rdy), 128'(1'b1));
        chk("t5b_ret_low", 128'(ret_valid), 128'(1'b0));
        step();
        req = 1'b0;
        chk("t5b_arvalid", 128'(axi.arvalid), 128'(1'b1));
        chk("t5b_araddr", 128'(axi.araddr), 128'h1000);
        chk("t5b_cleared", ret_data, 128'h0);
        ar_hs(0, 32'h0000_1000);
        beat(4'd0, 32'h1, 1'b0, 0);
        beat(4'd0, 32'h2, 1'b0, 0);
        beat(4'd0, 32'h3, 1'b0, 0);
        beat(4'd0, 32'h4, 1'b0, 0);
        chk("t5b_wait_rlast", 128'(ret_valid), 128'(1'b0));
        beat(4'd0, 32'h5, 1'b1, 0);
        done_chk("t5b", 128'h00000005_00000003_00000002_00000001);

        // 6: reset in the middle of the data phase
        accept(32'h2000_0040, 32'h2000_0040);
        ar_hs(0, 32'h2000_0040);
        beat(4'd0, 32'h11, 1'b0, 0);
        beat(4'd0, 32'h22, 1'b0, 0);
        p0 = pulses;
        reset = 1'b1;
        step();
        chk("t6_rdy_in_reset", 128'(rdy), 128'(1'b0));
        chk("t6_rready", 128'(axi.rready), 128'(1'b0));
        chk("t6_arvalid", 128'(axi.arvalid), 128'(1'b0));
        chk("t6_ret_data", ret_data, 128'h0);
        chk("t6_araddr", 128'(axi.araddr), 128'h0);
        reset = 1'b0;
        #1;
        chk("t6_rdy", 128'(rdy), 128'(1'b1));
        step();
        step();
        chk("t6_no_pulse", 128'(pulses - p0), 128'(0));
        accept(32'h3000_0008, 32'h3000_0000);
        ar_hs(0, 32'h3000_0000);
        four_beats(32'hAA, 32'hBB, 32'hCC, 32'hDD);
        done_chk("t6", 128'h000000DD_000000CC_000000BB_000000AA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
